// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared control encodings, parameter record layout and scanner states
package accel_pkg;

  // Top-level control FSM encodings
  localparam logic [2:0] CTL_IDLE       = 3'b000;
  localparam logic [2:0] CTL_GET_PARAM  = 3'b001;
  localparam logic [2:0] CTL_LOAD       = 3'b010;
  localparam logic [2:0] CTL_COMPUTE    = 3'b011;
  localparam logic [2:0] CTL_ACCUM      = 3'b100;
  localparam logic [2:0] CTL_STORE      = 3'b101;
  localparam logic [2:0] CTL_WRITE_BACK = 3'b110;
  localparam logic [2:0] CTL_DONE       = 3'b111;

  // Packed iteration record: {z, i, l, k}, k in the low bits
  localparam int PARAM_W = 64;
  localparam int K_OFF   = 0;
  localparam int K_W     = 16;
  localparam int L_OFF   = 16;
  localparam int L_W     = 16;
  localparam int I_OFF   = 32;
  localparam int I_W     = 16;
  localparam int Z_OFF   = 48;
  localparam int Z_W     = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } scan_state_e;

  function automatic logic [PARAM_W-1:0] pack_param(
    input logic [K_W-1:0] k,
    input logic [L_W-1:0] l,
    input logic [I_W-1:0] i,
    input logic [Z_W-1:0] z
  );
    return {z, i, l, k};
  endfunction

endpackage

// File: rtl/rr_pending_scan.sv
// rtl/rr_pending_scan.sv - rotating priority encoder: first set bit at or after ptr
module rr_pending_scan #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] pending_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] hit_idx_o
);

  // Walk from the farthest offset back toward ptr so the nearest set slot wins
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (pending_i[ptr_i + IDX_W'(k)]) begin
        hit_o     = 1'b1;
        hit_idx_o = ptr_i + IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/param_finder.sv
// rtl/param_finder.sv - pending parameter table with round-robin finder; PARAM_FINDER_FAST_SCAN_EN selects one-cycle scan
module param_finder #(
  parameter int DEPTH   = 16,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int PARAM_W = accel_pkg::PARAM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         state,
  input  logic               push_valid,
  input  logic [PARAM_W-1:0] push_param,
  output logic               push_ready,
  input  logic               wb_valid,
  input  logic               wb_retire,
  input  logic [PARAM_W-1:0] wb_param,
  output logic               is_find,
  output logic [IDX_W-1:0]   cur_idx,
  output logic [PARAM_W-1:0] cur_param,
  output logic               is_finish
);
  import accel_pkg::*;

  scan_state_e        scan_q, scan_d;
  logic [PARAM_W-1:0] table_q [DEPTH];
  logic [DEPTH-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]   ptr_q, cur_idx_q;
  logic [PARAM_W-1:0] cur_param_q;
  logic               started_q, started_d;
  logic               is_find_q, is_finish_q;

  logic               scan_hit;
  logic [IDX_W-1:0]   scan_idx, ptr_next;
  logic               free_hit;
  logic [IDX_W-1:0]   free_idx;
  logic               push_fire, wb_fire, in_get;

`ifdef PARAM_FINDER_FAST_SCAN_EN
  rr_pending_scan #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_scan (
    .pending_i (pending_q),
    .ptr_i     (ptr_q),
    .hit_o     (scan_hit),
    .hit_idx_o (scan_idx)
  );

  // Lowest free slot: same encoder over the free mask, anchored at slot 0
  rr_pending_scan #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_free (
    .pending_i (~pending_q),
    .ptr_i     ('0),
    .hit_o     (free_hit),
    .hit_idx_o (free_idx)
  );

  assign ptr_next = scan_hit ? scan_idx + IDX_W'(1) : ptr_q;
`else
  assign scan_hit = pending_q[ptr_q];
  assign scan_idx = ptr_q;
  assign ptr_next = ptr_q + IDX_W'(1);
  assign free_hit = ~&pending_q;

  // Lowest-index free slot for an incoming push
  always_comb begin
    free_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!pending_q[k]) free_idx = IDX_W'(k);
    end
  end
`endif

  assign in_get     = (state == CTL_GET_PARAM);
  assign push_ready = free_hit;
  // Free-slot search sees pending before this cycle's retire, so a retiring slot is not reused yet
  assign push_fire  = push_valid && free_hit;
  assign wb_fire    = (scan_q == S_HOLD) && wb_valid;
  assign started_d  = started_q | push_fire;

  // Scanner next state
  always_comb begin
    scan_d = scan_q;
    unique case (scan_q)
      S_IDLE:  if (in_get) scan_d = S_SCAN;
      S_SCAN:  if (!in_get) scan_d = S_IDLE;
               else if (scan_hit) scan_d = S_HOLD;
      S_HOLD:  if (wb_valid) scan_d = S_IDLE;
      default: scan_d = S_IDLE;
    endcase
  end

  // Pending mask after retire and push; they never target the same slot
  always_comb begin
    pending_d = pending_q;
    if (wb_fire && wb_retire) pending_d[cur_idx_q] = 1'b0;
    if (push_fire) pending_d[free_idx] = 1'b1;
  end

  // Scanner state, pointer, captured record and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q      <= S_IDLE;
      pending_q   <= '0;
      ptr_q       <= '0;
      started_q   <= 1'b0;
      cur_idx_q   <= '0;
      cur_param_q <= '0;
      is_find_q   <= 1'b0;
      is_finish_q <= 1'b0;
    end else begin
      scan_q      <= scan_d;
      pending_q   <= pending_d;
      started_q   <= started_d;
      is_find_q   <= 1'b0;
      is_finish_q <= is_finish_q | (started_d && (pending_d == '0) && (scan_d != S_HOLD));
      if (scan_q == S_SCAN && in_get) begin
        ptr_q <= ptr_next;
        if (scan_hit) begin
          is_find_q   <= 1'b1;
          cur_idx_q   <= scan_idx;
          cur_param_q <= table_q[scan_idx];
        end
      end
    end
  end

  // Record storage: write-back update of the in-flight slot and push into a free slot
  always_ff @(posedge clk) begin
    if (wb_fire && !wb_retire) table_q[cur_idx_q] <= wb_param;
    if (push_fire) table_q[free_idx] <= push_param;
  end

  assign is_find   = is_find_q;
  assign cur_idx   = cur_idx_q;
  assign cur_param = cur_param_q;
  assign is_finish = is_finish_q;

endmodule
